// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: decodes the instruction class, resolves operands with
// EX/MEM forwarding, detects load-use hazards and registers the result into ID/EX.
module decode_stage #(
  parameter int ARCH_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  input  logic [31:0]          inInstr,
  input  logic [ARCH_BITS-1:0] inPc,
  output logic                 stallOut,
  input  logic                 flush,
  input  logic                 exStall,
  output logic [4:0]           rfSrc1,
  output logic [4:0]           rfSrc2,
  input  logic [ARCH_BITS-1:0] rfData1,
  input  logic [ARCH_BITS-1:0] rfData2,
  input  logic [ARCH_BITS-1:0] exResult,
  input  logic                 memWrEn,
  input  logic [4:0]           memDst,
  input  logic [ARCH_BITS-1:0] memData,
  output logic                 idValid,
  output logic [6:0]           idOpcode,
  output logic [4:0]           idDst,
  output logic [ARCH_BITS-1:0] idPc,
  output logic [ARCH_BITS-1:0] idOp1,
  output logic [ARCH_BITS-1:0] idOp2,
  output logic [ARCH_BITS-1:0] idImm,
  output logic                 idWrEn,
  output logic                 idIsLoad,
  output logic                 idIsStore,
  output logic                 idIsBranch,
  output logic [15:0]          stallCount
);

  localparam logic [6:0] OP_RMAX = 7'h0F;
  localparam logic [6:0] OP_ADDI = 7'h10;
  localparam logic [6:0] OP_LDW  = 7'h11;
  localparam logic [6:0] OP_STW  = 7'h12;
  localparam logic [6:0] OP_BEQ  = 7'h30;

  logic [6:0]           w_opcode;
  logic [4:0]           w_dst;
  logic [4:0]           w_src1;
  logic [4:0]           w_src2;
  logic                 w_use1;
  logic                 w_use2;
  logic                 w_wr;
  logic                 w_load;
  logic                 w_store;
  logic                 w_branch;
  logic                 w_hazard;
  logic                 w_exFwdOk;
  logic [ARCH_BITS-1:0] w_op1;
  logic [ARCH_BITS-1:0] w_op2;
  logic [ARCH_BITS-1:0] w_imm;

  logic                 r_valid;
  logic [6:0]           r_opcode;
  logic [4:0]           r_dst;
  logic [ARCH_BITS-1:0] r_pc;
  logic [ARCH_BITS-1:0] r_op1;
  logic [ARCH_BITS-1:0] r_op2;
  logic [ARCH_BITS-1:0] r_imm;
  logic                 r_wrEn;
  logic                 r_isLoad;
  logic                 r_isStore;
  logic                 r_isBranch;
  logic [15:0]          r_stallCount;

  assign w_opcode = inInstr[31:25];
  assign w_dst    = inInstr[24:20];
  assign w_src1   = inInstr[19:15];
  assign w_src2   = inInstr[14:10];
  assign w_imm    = {{(ARCH_BITS-15){inInstr[14]}}, inInstr[14:0]};
  assign rfSrc1   = w_src1;
  assign rfSrc2   = w_src2;

  always_comb begin
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_wr     = 1'b0;
    w_load   = 1'b0;
    w_store  = 1'b0;
    w_branch = 1'b0;
    if (w_opcode <= OP_RMAX) begin
      w_use1 = 1'b1;
      w_use2 = 1'b1;
      w_wr   = 1'b1;
    end else begin
      case (w_opcode)
        OP_ADDI: begin
          w_use1 = 1'b1;
          w_wr   = 1'b1;
        end
        OP_LDW: begin
          w_use1 = 1'b1;
          w_wr   = 1'b1;
          w_load = 1'b1;
        end
        OP_STW: begin
          w_use1  = 1'b1;
          w_use2  = 1'b1;
          w_store = 1'b1;
        end
        OP_BEQ: begin
          w_use1   = 1'b1;
          w_use2   = 1'b1;
          w_branch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A load in ID/EX has no result yet, so it can never forward from EX.
  assign w_exFwdOk = r_valid && r_wrEn && !r_isLoad;

  always_comb begin
    w_op1 = rfData1;
    if (w_use1) begin
      if (w_exFwdOk && (r_dst == w_src1))        w_op1 = exResult;
      else if (memWrEn && (memDst == w_src1))    w_op1 = memData;
    end
  end

  always_comb begin
    w_op2 = rfData2;
    if (w_use2) begin
      if (w_exFwdOk && (r_dst == w_src2))        w_op2 = exResult;
      else if (memWrEn && (memDst == w_src2))    w_op2 = memData;
    end
  end

  assign w_hazard = r_valid && r_isLoad && inValid &&
                    ((w_use1 && (w_src1 == r_dst)) || (w_use2 && (w_src2 == r_dst)));

  assign stallOut = !rst && !flush && (exStall || w_hazard);

  // Priority: reset, flush, execute back-pressure (hold), load-use bubble, normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_dst        <= '0;
      r_pc         <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_imm        <= '0;
      r_wrEn       <= 1'b0;
      r_isLoad     <= 1'b0;
      r_isStore    <= 1'b0;
      r_isBranch   <= 1'b0;
      r_stallCount <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_wrEn     <= 1'b0;
      r_isLoad   <= 1'b0;
      r_isStore  <= 1'b0;
      r_isBranch <= 1'b0;
    end else if (exStall) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid    <= 1'b0;
      r_wrEn     <= 1'b0;
      r_isLoad   <= 1'b0;
      r_isStore  <= 1'b0;
      r_isBranch <= 1'b0;
      if (r_stallCount != 16'hFFFF) r_stallCount <= r_stallCount + 16'd1;
    end else begin
      r_valid    <= inValid;
      r_opcode   <= w_opcode;
      r_dst      <= w_dst;
      r_pc       <= inPc;
      r_op1      <= w_op1;
      r_op2      <= w_op2;
      r_imm      <= w_imm;
      r_wrEn     <= inValid && w_wr;
      r_isLoad   <= inValid && w_load;
      r_isStore  <= inValid && w_store;
      r_isBranch <= inValid && w_branch;
    end
  end

  assign idValid    = r_valid;
  assign idOpcode   = r_opcode;
  assign idDst      = r_dst;
  assign idPc       = r_pc;
  assign idOp1      = r_op1;
  assign idOp2      = r_op2;
  assign idImm      = r_imm;
  assign idWrEn     = r_wrEn;
  assign idIsLoad   = r_isLoad;
  assign idIsStore  = r_isStore;
  assign idIsBranch = r_isBranch;
  assign stallCount = r_stallCount;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table for the pipeline corner cases, then
// randomized traffic compared against an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, inValid, flush, exStall, memWrEn;
  logic [31:0] inInstr, inPc, rfData1, rfData2, exResult, memData;
  logic [4:0]  memDst, rfSrc1, rfSrc2, idDst;
  logic        stallOut, idValid, idWrEn, idIsLoad, idIsStore, idIsBranch;
  logic [6:0]  idOpcode;
  logic [31:0] idPc, idOp1, idOp2, idImm;
  logic [15:0] stallCount;

  int nVec = 0;
  int nCmp = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  decode_stage #(.ARCH_BITS(32)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inInstr(inInstr), .inPc(inPc),
    .stallOut(stallOut), .flush(flush), .exStall(exStall),
    .rfSrc1(rfSrc1), .rfSrc2(rfSrc2), .rfData1(rfData1), .rfData2(rfData2),
    .exResult(exResult), .memWrEn(memWrEn), .memDst(memDst), .memData(memData),
    .idValid(idValid), .idOpcode(idOpcode), .idDst(idDst), .idPc(idPc),
    .idOp1(idOp1), .idOp2(idOp2), .idImm(idImm), .idWrEn(idWrEn),
    .idIsLoad(idIsLoad), .idIsStore(idIsStore), .idIsBranch(idIsBranch),
    .stallCount(stallCount)
  );

  typedef struct {
    logic        rst, fl, xs;
    logic [31:0] instr, rf1, rf2, exr;
    logic        mw;
    logic [4:0]  md;
    logic [31:0] mdata;
    logic        eStall, eValid, eWr, eLd;
    logic [15:0] eCnt;
    logic        c1;
    logic [31:0] eOp1;
    logic        c2;
    logic [31:0] eOp2;
    logic        cF;
    logic [4:0]  eDst;
    logic [31:0] eImm;
  } vec_t;

  typedef struct {
    logic        v, wr, ld, st, br, fz, known, u1, u2;
    logic [6:0]  op;
    logic [4:0]  dst;
    logic [31:0] pc, op1, op2, imm;
    logic [15:0] cnt;
  } mst_t;

  vec_t tbl[$];
  mst_t m;

  function automatic logic [31:0] ins(logic [6:0] op, logic [4:0] d, logic [4:0] s1, logic [14:0] low);
    return {op, d, s1, low};
  endfunction

  function automatic logic [31:0] rins(logic [6:0] op, logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
    return {op, d, s1, s2, 10'b0};
  endfunction

  function automatic vec_t mk(logic r, logic fl, logic xs, logic [31:0] instr,
                              logic [31:0] rf1, logic [31:0] rf2, logic [31:0] exr,
                              logic mw, logic [4:0] md, logic [31:0] mdata,
                              logic eStall, logic eValid, logic eWr, logic eLd, logic [15:0] eCnt,
                              logic c1, logic [31:0] eOp1, logic c2, logic [31:0] eOp2,
                              logic cF, logic [4:0] eDst, logic [31:0] eImm);
    vec_t t;
    t.rst = r; t.fl = fl; t.xs = xs; t.instr = instr;
    t.rf1 = rf1; t.rf2 = rf2; t.exr = exr; t.mw = mw; t.md = md; t.mdata = mdata;
    t.eStall = eStall; t.eValid = eValid; t.eWr = eWr; t.eLd = eLd; t.eCnt = eCnt;
    t.c1 = c1; t.eOp1 = eOp1; t.c2 = c2; t.eOp2 = eOp2;
    t.cF = cF; t.eDst = eDst; t.eImm = eImm;
    return t;
  endfunction

  // {use1, use2, writes, load, store, branch} from the opcode class table.
  function automatic logic [5:0] cls(logic [6:0] op);
    int o = int'(op);
    if (o <= 15) return 6'b111000;
    if (o == 16) return 6'b101000;
    if (o == 17) return 6'b101100;
    if (o == 18) return 6'b110010;
    if (o == 48) return 6'b110001;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] sext15(logic [31:0] instr);
    int v = int'(instr[14:0]);
    if (v >= 16384) v = v - 32768;
    return 32'(v);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t t, input logic [31:0] pc);
    rst = t.rst; inValid = 1'b1; inInstr = t.instr; inPc = pc;
    flush = t.fl; exStall = t.xs; rfData1 = t.rf1; rfData2 = t.rf2;
    exResult = t.exr; memWrEn = t.mw; memDst = t.md; memData = t.mdata;
    nVec++;
  endtask

  task automatic checkOutput(input vec_t t, input int idx);
    string s;
    s = $sformatf("row%0d", idx);
    cmp({s, ".idValid"}, 32'(idValid), 32'(t.eValid));
    cmp({s, ".idWrEn"}, 32'(idWrEn), 32'(t.eWr));
    cmp({s, ".idIsLoad"}, 32'(idIsLoad), 32'(t.eLd));
    cmp({s, ".stallCount"}, 32'(stallCount), 32'(t.eCnt));
    if (t.cF) begin
      cmp({s, ".idDst"}, 32'(idDst), 32'(t.eDst));
      cmp({s, ".idImm"}, idImm, t.eImm);
    end
    if (t.c1) cmp({s, ".idOp1"}, idOp1, t.eOp1);
    if (t.c2) cmp({s, ".idOp2"}, idOp2, t.eOp2);
  endtask

  initial begin
    logic [31:0] ldw7, add8, addi9, ldw14, add15;
    ldw7  = ins(7'h11, 5'd7, 5'd1, 15'd4);
    add8  = rins(7'h00, 5'd8, 5'd7, 5'd2);
    addi9 = ins(7'h10, 5'd9, 5'd8, 15'd1);
    ldw14 = ins(7'h11, 5'd14, 5'd1, 15'd0);
    add15 = rins(7'h00, 5'd15, 5'd14, 5'd14);

    //            rst fl xs instr                          rf1       rf2  exr        mw md     mdata      stl vl wr ld cnt   c1 op1          c2 op2         cF dst    imm
    tbl.push_back(mk(1, 0, 0, rins(7'h00, 5'd3, 5'd1, 5'd2), 1,        2,   0,         0, 5'd0,  0,         0,  0, 0, 0, 16'd0, 1, 0,           1, 0,          1, 5'd0,  32'h0));
    tbl.push_back(mk(0, 0, 0, rins(7'h00, 5'd3, 5'd1, 5'd2), 1,        2,   0,         0, 5'd0,  0,         0,  1, 1, 0, 16'd0, 1, 1,           1, 2,          1, 5'd3,  32'h800));
    tbl.push_back(mk(0, 0, 0, rins(7'h01, 5'd5, 5'd1, 5'd2), 1,        2,   0,         0, 5'd0,  0,         0,  1, 1, 0, 16'd0, 1, 1,           1, 2,          1, 5'd5,  32'h800));
    tbl.push_back(mk(0, 0, 0, rins(7'h00, 5'd6, 5'd5, 5'd2), 32'h11,   2,   32'h55,    1, 5'd5,  32'h99,    0,  1, 1, 0, 16'd0, 1, 32'h55,      1, 2,          1, 5'd6,  32'h800));
    tbl.push_back(mk(0, 0, 0, ldw7,                          32'h1000, 32'h22, 0,      0, 5'd0,  0,         0,  1, 1, 1, 16'd0, 1, 32'h1000,    0, 0,          1, 5'd7,  32'h4));
    tbl.push_back(mk(0, 0, 0, add8,                          0,        2,   0,         0, 5'd0,  0,         1,  0, 0, 0, 16'd1, 0, 0,           0, 0,          0, 5'd0,  32'h0));
    tbl.push_back(mk(0, 0, 0, add8,                          0,        2,   0,         1, 5'd7,  32'h1234,  0,  1, 1, 0, 16'd1, 1, 32'h1234,    1, 2,          1, 5'd8,  32'h800));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 0, 1, addi9,                       0,        0,   32'h4444,  0, 5'd0,  0,         1,  1, 1, 0, 16'd1, 1, 32'h1234,    1, 2,          1, 5'd8,  32'h800));
    tbl.push_back(mk(0, 0, 0, ins(7'h11, 5'd10, 5'd1, 15'd0), 32'h2000, 0,   0,         0, 5'd0,  0,         0,  1, 1, 1, 16'd1, 1, 32'h2000,    0, 0,          1, 5'd10, 32'h0));
    tbl.push_back(mk(0, 1, 1, rins(7'h00, 5'd11, 5'd10, 5'd2), 0,       2,   0,         0, 5'd0,  0,         0,  0, 0, 0, 16'd1, 0, 0,           0, 0,          0, 5'd0,  32'h0));
    tbl.push_back(mk(0, 0, 0, ins(7'h10, 5'd12, 5'd1, 15'h7FFF), 5,     0,   0,         0, 5'd0,  0,         0,  1, 1, 0, 16'd1, 1, 5,           0, 0,          1, 5'd12, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 0, 0, ins(7'h10, 5'd13, 5'd12, 15'h3FFF), 9,    0,   32'h77,    0, 5'd0,  0,         0,  1, 1, 0, 16'd1, 1, 32'h77,      0, 0,          1, 5'd13, 32'h3FFF));
    tbl.push_back(mk(0, 0, 0, ldw14,                         3,        0,   0,         0, 5'd0,  0,         0,  1, 1, 1, 16'd1, 1, 3,           0, 0,          1, 5'd14, 32'h0));
    tbl.push_back(mk(0, 0, 1, add15,                         0,        0,   0,         0, 5'd0,  0,         1,  1, 1, 1, 16'd1, 1, 3,           0, 0,          1, 5'd14, 32'h0));
    tbl.push_back(mk(0, 0, 0, add15,                         0,        0,   0,         0, 5'd0,  0,         1,  0, 0, 0, 16'd2, 0, 0,           0, 0,          0, 5'd0,  32'h0));
    tbl.push_back(mk(0, 0, 0, ins(7'h11, 5'd16, 5'd1, 15'd0), 3,        0,   0,         0, 5'd0,  0,         0,  1, 1, 1, 16'd2, 1, 3,           0, 0,          1, 5'd16, 32'h0));
    tbl.push_back(mk(1, 0, 0, rins(7'h00, 5'd17, 5'd16, 5'd1), 4,       4,   0,         0, 5'd0,  0,         0,  0, 0, 0, 16'd0, 1, 0,           1, 0,          1, 5'd0,  32'h0));
    tbl.push_back(mk(0, 0, 0, rins(7'h00, 5'd0, 5'd1, 5'd2),  1,        2,   0,         0, 5'd0,  0,         0,  1, 1, 0, 16'd0, 1, 1,           1, 2,          1, 5'd0,  32'h800));
    tbl.push_back(mk(0, 0, 0, rins(7'h00, 5'd1, 5'd0, 5'd0),  7,        7,   32'hABC,   1, 5'd0,  5,         0,  1, 1, 0, 16'd0, 1, 32'hABC,     1, 32'hABC,    1, 5'd1,  32'h0));
    tbl.push_back(mk(0, 0, 0, ins(7'h7F, 5'd20, 5'd3, 15'd0), 1,        1,   0,         0, 5'd0,  0,         0,  1, 0, 0, 16'd0, 0, 0,           0, 0,          1, 5'd20, 32'h0));
    tbl.push_back(mk(0, 0, 0, rins(7'h12, 5'd21, 5'd1, 5'd2), 4,        5,   0,         1, 5'd2,  32'h66,    0,  1, 0, 0, 16'd0, 1, 4,           1, 32'h66,     1, 5'd21, 32'h800));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], 32'h100 + 32'(i * 4));
      #2;
      cmp($sformatf("row%0d.stallOut", i), 32'(stallOut), 32'(tbl[i].eStall));
      @(posedge clk);
      #1;
      checkOutput(tbl[i], i);
    end

    for (int i = 0; i < 500; i++) begin
      logic [5:0]  c;
      logic [6:0]  op;
      logic [4:0]  s1, s2, d;
      logic        haz, expStall, exFwd;
      logic [31:0] o1, o2;
      int          sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    op = 7'($urandom_range(0, 15));
        2:       op = 7'h10;
        3, 4:    op = 7'h11;
        5:       op = 7'h12;
        6:       op = 7'h30;
        default: op = 7'($urandom_range(0, 127));
      endcase
      d  = 5'($urandom_range(0, 3));
      s1 = 5'($urandom_range(0, 3));
      s2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      rst      = (i == 0) || ($urandom_range(0, 59) == 0);
      inValid  = ($urandom_range(0, 7) != 0);
      inInstr  = {op, d, s1, s2, 10'($urandom)};
      inPc     = $urandom;
      flush    = ($urandom_range(0, 9) == 0);
      exStall  = ($urandom_range(0, 5) == 0);
      rfData1  = $urandom;
      rfData2  = $urandom;
      exResult = $urandom;
      memWrEn  = 1'($urandom_range(0, 1));
      memDst   = 5'($urandom_range(0, 3));
      memData  = $urandom;
      nVec++;
      #2;
      c   = cls(op);
      haz = (i != 0) && m.v && m.ld && inValid && ((c[5] && s1 == m.dst) || (c[4] && s2 == m.dst));
      expStall = !rst && !flush && (exStall || haz);
      cmp("rnd.stallOut", 32'(stallOut), 32'(expStall));
      cmp("rnd.rfSrc1", 32'(rfSrc1), 32'(s1));
      cmp("rnd.rfSrc2", 32'(rfSrc2), 32'(s2));
      exFwd = m.v && m.wr && !m.ld;
      o1 = rfData1;
      o2 = rfData2;
      if (c[5]) o1 = (exFwd && m.dst == s1) ? exResult : (memWrEn && memDst == s1) ? memData : rfData1;
      if (c[4]) o2 = (exFwd && m.dst == s2) ? exResult : (memWrEn && memDst == s2) ? memData : rfData2;
      if (rst) begin
        m = '{v: 1'b0, wr: 1'b0, ld: 1'b0, st: 1'b0, br: 1'b0, fz: 1'b1, known: 1'b1,
              u1: 1'b1, u2: 1'b1, op: 7'd0, dst: 5'd0, pc: 32'd0, op1: 32'd0,
              op2: 32'd0, imm: 32'd0, cnt: 16'd0};
      end else if (flush || (!exStall && haz)) begin
        m.v = 1'b0; m.wr = 1'b0; m.ld = 1'b0; m.st = 1'b0; m.br = 1'b0;
        m.fz = 1'b1; m.known = 1'b0;
        if (!flush && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
      end else if (!exStall) begin
        m.v = inValid; m.fz = 1'b0; m.known = inValid;
        m.wr = c[3]; m.ld = c[2]; m.st = c[1]; m.br = c[0];
        m.u1 = c[5]; m.u2 = c[4];
        m.op = op; m.dst = d; m.pc = inPc; m.imm = sext15(inInstr);
        m.op1 = o1; m.op2 = o2;
      end
      @(posedge clk);
      #1;
      cmp("rnd.idValid", 32'(idValid), 32'(m.v));
      cmp("rnd.stallCount", 32'(stallCount), 32'(m.cnt));
      if (m.v || m.fz) begin
        cmp("rnd.flags", {28'd0, idWrEn, idIsLoad, idIsStore, idIsBranch},
            {28'd0, m.wr, m.ld, m.st, m.br});
      end
      if (m.known) begin
        cmp("rnd.idOpcode", 32'(idOpcode), 32'(m.op));
        cmp("rnd.idDst", 32'(idDst), 32'(m.dst));
        cmp("rnd.idPc", idPc, m.pc);
        cmp("rnd.idImm", idImm, m.imm);
        if (m.u1) cmp("rnd.idOp1", idOp1, m.op1);
        if (m.u2) cmp("rnd.idOp2", idOp2, m.op2);
      end
    end

    $display("[TB] %0d comparisons made", nCmp);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode / operand-fetch stage of the in-order pipeline. Sits between fetch and execute, and drives the register file's two read ports. It resolves operands with EX/MEM forwarding and detects load-use hazards, inserting one bubble and stalling fetch. It registers the decoded instruction into the ID/EX pipeline register consumed by the execute stage.

## Interface
- ARCH_BITS, 32, datapath width; must equal the processor-wide ARCH_BITS.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inValid  in  1  fetch presents a valid instruction.
- inInstr  in  32  instruction: opcode[31:25], dst[24:20], src1[19:15], src2[14:10], imm[14:0].
- inPc  in  ARCH_BITS  PC of inInstr.
- stallOut  out  1  fetch must hold inInstr/inPc this cycle (combinational).
- flush  in  1  branch redirect from EX; kill current decode and ID/EX contents.
- exStall  in  1  execute cannot accept a new instruction this cycle.
- rfSrc1, rfSrc2  out  5  register file read addresses (combinational = inInstr src fields).
- rfData1, rfData2  in  ARCH_BITS  register file read data.
- exResult  in  ARCH_BITS  ALU result of the instruction currently held in ID/EX.
- memWrEn  in  1  MEM-stage instruction writes a register; memDst in 5; memData in ARCH_BITS.
- idValid  out  1  ID/EX holds a live instruction.
- idOpcode out 7; idDst out 5; idPc out ARCH_BITS.
- idOp1, idOp2  out  ARCH_BITS  resolved source operands.
- idImm  out  ARCH_BITS  imm[14:0] sign-extended.
- idWrEn, idIsLoad, idIsStore, idIsBranch  out  1  decoded class flags.
- stallCount  out  16  saturating count of load-use bubbles.

## Operation
- Opcode classes: 0x00–0x0F R-type (reads src1,src2; writes dst); 0x10 ADDI (src1; writes); 0x11 LDW (src1; writes; load); 0x12 STW (src1,src2; store); 0x30 BEQ (src1,src2; branch); 0x7F and all others NOP (no reads, no write, idValid still follows inValid).
- Source "used" only per class above; unused sources never cause hazards or forwarding.
- Operand priority per used source: (1) idValid && idWrEn && !idIsLoad && idDst==src -> exResult; (2) memWrEn && memDst==src -> memData; (3) rfDataN. No register is hardwired to zero; r0 forwards like any other.
- WB needs no forward: register file writes on the falling edge, so same-cycle reads return the new value.
- Load-use hazard: idValid && idIsLoad && inValid && a used source == idDst. Then: stallOut=1, ID/EX loads a bubble (idValid=0, all flags 0), stallCount increments (saturates at 0xFFFF).
- exStall=1: ID/EX holds all fields; stallOut=1; no bubble counted.
- flush=1 (highest priority, overrides exStall and hazard): next edge idValid=0, flags 0; stallOut=0; stallCount unchanged.
- Otherwise: ID/EX loads decode of inInstr with idValid=inValid; stallOut=0.
- Unused operand outputs (e.g. idOp2 for ADDI) carry rfData2/forwarded value unchanged; EX ignores them.

## Timing
- Decode-to-ID/EX latency: 1 cycle.
- Load-use costs exactly one bubble; the following cycle the load is in MEM and the operand comes from memData.
- stallOut, rfSrc1, rfSrc2 are combinational from inputs and current ID/EX state.
- Reset: idValid=0, all id* fields 0, stallCount=0; stallOut=0 during reset. Reset mid-stall discards the held instruction.
- Simultaneous flush+exStall: flush wins. Simultaneous hazard+exStall: hold (exStall), no bubble, no count.

## Test plan
- R-type ADD r3,r1,r2 with no hazards after reset (r1=1,r2=2) -> next cycle idValid=1, idOp1=1, idOp2=2, idDst=3, idWrEn=1.
- ADD r5 producing exResult=0x55 in ID/EX, next instr reads r5 -> idOp1=0x55 (EX forward beats MEM with memDst=5, memData=0x99).
- LDW r7 in ID/EX, next ADD reads r7 -> stallOut=1 one cycle, bubble (idValid=0), stallCount=1; next cycle memData=0x1234 forwarded into idOp1.
- exStall held 3 cycles -> ID/EX fields constant, stallOut=1, stallCount unchanged.
- flush together with exStall and load-use hazard -> next edge idValid=0, stallOut=0, stallCount unchanged.
- ADDI with imm=0x7FFF -> idImm=0xFFFFFFFF; imm=0x3FFF -> 0x00003FFF; assert rst mid-operation -> all outputs 0 next edge.
